// File: rtl/latch_bank.sv
// rtl/latch_bank.sv - bank of enable-loaded channels with snapshot and streamed readout
// Ports:
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   en, d           : per-channel load enables, shared load data
//   q               : live channel contents, channel i at [i*WIDTH +: WIDTH]
//   snap            : freeze every channel into the shadow bank and start a stream
//   out_data, out_idx, out_valid, out_ready : shadow readout, one channel per handshake
//   busy            : stream in progress
//   ovf, clr_ovf    : sticky dropped-snapshot flag and its clear
module latch_bank #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  localparam int IDXW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       en,
  input  logic [WIDTH-1:0]     d,
  output logic [NCH*WIDTH-1:0] q,
  input  logic                 snap,
  output logic [WIDTH-1:0]     out_data,
  output logic [IDXW-1:0]      out_idx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 ovf,
  input  logic                 clr_ovf
);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

  state_t                    state_q, state_d;
  logic [NCH-1:0][WIDTH-1:0] q_q, q_d;
  logic [NCH-1:0][WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0]          out_data_q, out_data_d;
  logic [IDXW-1:0]           out_idx_q, out_idx_d;
  logic [IDXW-1:0]           next_idx;
  logic                      out_valid_q, out_valid_d;
  logic                      ovf_q, ovf_d;
  logic                      overrun;

  always_comb begin
    q_d = q_q;
    for (int i = 0; i < NCH; i++) begin
      if (en[i]) begin
        q_d[i] = d;
      end
    end

    state_d     = state_q;
    shadow_d    = shadow_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    overrun     = 1'b0;
    next_idx    = out_idx_q + 1'b1;

    case (state_q)
      IDLE: begin
        // Snapshot takes the pre-edge q so a same-cycle load is excluded.
        if (snap) begin
          shadow_d    = q_q;
          out_idx_d   = '0;
          out_data_d  = q_q[0];
          out_valid_d = 1'b1;
          state_d     = STREAM;
        end
      end
      STREAM: begin
        overrun = snap;
        if (out_ready) begin
          if (out_idx_q == LAST_IDX) begin
            out_idx_d   = '0;
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end else begin
            // Preload the next word so out_data stays a plain register output.
            out_idx_d  = next_idx;
            out_data_d = shadow_q[next_idx];
          end
        end
      end
    endcase

    // Set has priority over clear so a same-cycle overrun is never lost.
    if (overrun) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      q_q         <= '0;
      shadow_q    <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      shadow_q    <= shadow_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign q         = q_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_valid = out_valid_q;
  assign busy      = out_valid_q;
  assign ovf       = ovf_q;

endmodule
